// File: rtl/fetch_pkg.sv
// Shared fetch types: FSM states, queue depth and the {pc, instr} entry carried to decode.
// No logic or storage; latency and backpressure are set by the modules that import it.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    localparam int FETCH_Q_DEPTH    = 2;
    localparam int FETCH_DATA_WIDTH = 32;
    localparam int FETCH_CNT_W      = $clog2(FETCH_Q_DEPTH + 1);
    localparam int FETCH_PTR_W      = $clog2(FETCH_Q_DEPTH);

    typedef struct packed {
        logic [31:0]                 pc;
        logic [FETCH_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] byte_pc);
        return byte_pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr}; an entry is visible at the head the cycle after push.
// Pushes into a full queue are dropped unless a pop frees a slot that same cycle; flush empties it.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  fetch_entry_t           push_dat_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [FETCH_CNT_W-1:0] count_o,
    output logic                   head_vld_o,
    output fetch_entry_t           head_dat_o
);

    localparam logic [FETCH_CNT_W-1:0] DEPTH_C = FETCH_CNT_W'(FETCH_Q_DEPTH);

    fetch_entry_t             entry_q [FETCH_Q_DEPTH];
    logic [FETCH_PTR_W-1:0]   rd_ptr_q;
    logic [FETCH_PTR_W-1:0]   wr_ptr_q;
    logic [FETCH_CNT_W-1:0]   count_q;
    logic                     pop_ok;
    logic                     push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q < DEPTH_C) || pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FETCH_Q_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                entry_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + FETCH_CNT_W'(push_ok) - FETCH_CNT_W'(pop_ok);
        end
    end

    assign count_o    = count_q;
    assign head_vld_o = (count_q != '0);
    // An empty queue presents zeros so decode never sees a stale entry.
    assign head_dat_o = head_vld_o ? entry_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// PC owner and InstructionMemory initiator; first instruction 4 cycles after reset, redirect target at t+4.
// Sustains one instruction per cycle; issue stalls when queued plus in-flight work reaches 2. Optional FETCH_PERF_EN counters.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [31:0]           inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           stall_count
`endif
);

    fetch_state_e           state_q;
    logic [31:0]            pc_q;
    logic                   inflight_q;
    logic [31:0]            inflight_pc_q;

    logic [FETCH_CNT_W-1:0] q_count;
    logic                   q_head_vld;
    fetch_entry_t           q_head;
    fetch_entry_t           push_dat;
    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [2:0]             occupancy;

    assign mem_addr = pc_q[ADDR_WIDTH+1:2];

    assign pop       = q_head_vld && inst_ready;
    assign occupancy = 3'(q_count) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == RUN) && !redirect_valid && (occupancy < 3'd2);

    // A response landing in the redirect cycle or during FLUSH belongs to the old stream.
    assign push     = inflight_q && (state_q != FLUSH) && !redirect_valid;
    assign push_dat = '{pc: inflight_pc_q, instr: mem_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect_valid) begin
            state_q    <= FLUSH;
            pc_q       <= word_align(redirect_pc);
            inflight_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q    <= RUN;
                    inflight_q <= 1'b0;
                end
                RUN: begin
                    inflight_q <= issue;
                    if (issue) begin
                        inflight_pc_q <= pc_q;
                        pc_q          <= pc_q + 32'd4;
                    end
                end
                FLUSH: begin
                    state_q    <= RUN;
                    inflight_q <= 1'b0;
                end
                default: begin
                    state_q    <= BOOT;
                    inflight_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .flush_i    (redirect_valid),
        .count_o    (q_count),
        .head_vld_o (q_head_vld),
        .head_dat_o (q_head)
    );

    assign inst_valid = q_head_vld;
    assign inst_data  = q_head.instr;
    assign inst_pc    = q_head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (q_head_vld && !inst_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a synchronous word memory model behind two instances.
// Instance dut runs from PC 0; dut_w starts at 0xFFC to exercise the memory address wrap.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_w;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_ready_w;

    logic [9:0]  mem_addr,  mem_addr_w;
    logic [31:0] mem_data,  mem_data_w;
    logic        inst_valid, inst_valid_w;
    logic [31:0] inst_data, inst_data_w;
    logic [31:0] inst_pc,   inst_pc_w;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count, fetch_count_w, stall_count_w;
`endif

    logic [31:0] mem [1024];
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input int w);
        return 32'hCAFE_0000 | 32'(w);
    endfunction

    always @(posedge clk) begin
        mem_data   <= mem[mem_addr];
        mem_data_w <= mem[mem_addr_w];
    end

    instruction_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr(mem_addr), .mem_data(mem_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    instruction_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RESET_PC(32'h0000_0FFC)) dut_w (
        .clk(clk), .rst(rst_w), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .mem_addr(mem_addr_w), .mem_data(mem_data_w), .inst_valid(inst_valid_w),
        .inst_ready(inst_ready_w), .inst_data(inst_data_w), .inst_pc(inst_pc_w)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count_w), .stall_count(stall_count_w)
`endif
    );

    task automatic test_reset();
        rst = 1'b0; rst_w = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        inst_ready = 1'b1; inst_ready_w = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        tests_run++; if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
        tests_run++; if (inst_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", inst_data); end
        tests_run++; if (mem_addr !== 10'h000) begin tests_failed++; $display("FAIL reset_addr: got %h want 000", mem_addr); end
        tests_run++; if (mem_addr_w !== 10'h3FF) begin tests_failed++; $display("FAIL reset_addr_w: got %h want 3ff", mem_addr_w); end
`ifdef FETCH_PERF_EN
        tests_run++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin tests_failed++; $display("FAIL reset_perf: got %h/%h want 0/0", fetch_count, stall_count); end
`endif
    endtask

    // Releases reset at a falling edge; first instruction must appear on the third falling edge after.
    task automatic test_stream(input string tag);
        rst = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            @(negedge clk);
            tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_early_valid[%0d]: got %b want 0", tag, n, inst_valid); end
        end
        @(negedge clk);
        tests_run++; if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL %s_first_valid: got %b want 1", tag, inst_valid); end
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            tests_run++; if (inst_pc !== 32'(4 * k)) begin tests_failed++; $display("FAIL %s_pc[%0d]: got %h want %h", tag, k, inst_pc, 32'(4 * k)); end
            tests_run++; if (inst_data !== exp_word(k)) begin tests_failed++; $display("FAIL %s_data[%0d]: got %h want %h", tag, k, inst_data, exp_word(k)); end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        tests_run++; if (inst_pc !== 32'h10 || inst_data !== exp_word(4)) begin tests_failed++; $display("FAIL stall_entry: got %h/%h want 10/%h", inst_pc, inst_data, exp_word(4)); end
        inst_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10) begin tests_failed++; $display("FAIL stall_hold_pc[%0d]: got %b/%h want 1/10", n, inst_valid, inst_pc); end
            tests_run++; if (inst_data !== exp_word(4)) begin tests_failed++; $display("FAIL stall_hold_data[%0d]: got %h want %h", n, inst_data, exp_word(4)); end
        end
        inst_ready = 1'b1;
        for (int k = 5; k <= 7; k++) begin
            @(negedge clk);
            tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k)) begin tests_failed++; $display("FAIL stall_release_pc[%0d]: got %b/%h want 1/%h", k, inst_valid, inst_pc, 32'(4 * k)); end
            tests_run++; if (inst_data !== exp_word(k)) begin tests_failed++; $display("FAIL stall_release_data[%0d]: got %h want %h", k, inst_data, exp_word(k)); end
        end
    endtask

    // Shared redirect sequence: target 0x40 expected at t+4, nothing valid in between.
    task automatic run_redirect(input string tag, input logic [31:0] target);
        redirect_valid = 1'b1; redirect_pc = target;
        @(negedge clk);
        redirect_valid = 1'b0; inst_ready = 1'b1;
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_t1_valid: got %b want 0", tag, inst_valid); end
        @(negedge clk);
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_t2_valid: got %b want 0", tag, inst_valid); end
        tests_run++; if (mem_addr !== 10'd16) begin tests_failed++; $display("FAIL %s_t2_addr: got %h want 010", tag, mem_addr); end
        @(negedge clk);
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_t3_valid: got %b want 0", tag, inst_valid); end
        @(negedge clk);
        tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin tests_failed++; $display("FAIL %s_t4_pc: got %b/%h want 1/40", tag, inst_valid, inst_pc); end
        tests_run++; if (inst_data !== exp_word(16)) begin tests_failed++; $display("FAIL %s_t4_data: got %h want %h", tag, inst_data, exp_word(16)); end
        @(negedge clk);
        tests_run++; if (inst_pc !== 32'h44 || inst_data !== exp_word(17)) begin tests_failed++; $display("FAIL %s_t5: got %h/%h want 44/%h", tag, inst_pc, inst_data, exp_word(17)); end
    endtask

    task automatic test_redirect();
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (inst_pc !== 32'h1C) begin tests_failed++; $display("FAIL redirect_pre_hold: got %h want 1c", inst_pc); end
        run_redirect("redirect", 32'h40);
    endtask

    task automatic test_redirect_unaligned();
        run_redirect("unaligned", 32'h43);
    endtask

    task automatic test_wrap();
        rst_w = 1'b1;
        @(negedge clk);
        tests_run++; if (mem_addr_w !== 10'h3FF || inst_valid_w !== 1'b0) begin tests_failed++; $display("FAIL wrap_addr0: got %h/%b want 3ff/0", mem_addr_w, inst_valid_w); end
        @(negedge clk);
        tests_run++; if (mem_addr_w !== 10'h000) begin tests_failed++; $display("FAIL wrap_addr1: got %h want 000", mem_addr_w); end
        @(negedge clk);
        tests_run++; if (inst_valid_w !== 1'b1 || inst_pc_w !== 32'hFFC) begin tests_failed++; $display("FAIL wrap_pc0: got %b/%h want 1/ffc", inst_valid_w, inst_pc_w); end
        tests_run++; if (inst_data_w !== exp_word(1023)) begin tests_failed++; $display("FAIL wrap_data0: got %h want %h", inst_data_w, exp_word(1023)); end
        @(negedge clk);
        tests_run++; if (inst_pc_w !== 32'h1000) begin tests_failed++; $display("FAIL wrap_pc1: got %h want 1000", inst_pc_w); end
        tests_run++; if (inst_data_w !== exp_word(0)) begin tests_failed++; $display("FAIL wrap_data1: got %h want %h", inst_data_w, exp_word(0)); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_valid: got %b want 0", inst_valid); end
        tests_run++; if (mem_addr !== 10'h000) begin tests_failed++; $display("FAIL areset_addr: got %h want 000", mem_addr); end
        tests_run++; if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL areset_pc: got %h want 0", inst_pc); end
`ifdef FETCH_PERF_EN
        tests_run++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin tests_failed++; $display("FAIL areset_perf: got %h/%h want 0/0", fetch_count, stall_count); end
`endif
        repeat (2) @(negedge clk);
        test_stream("rerun");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = exp_word(i);
        test_reset();
        test_stream("stream");
        test_stall();
        test_redirect();
        test_redirect_unaligned();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch-side initiator for InstructionMemory: holds the PC, drives the word address, and captures the read data one cycle later.
- Presents {pc, instruction} pairs to the decode stage through a valid/ready handshake, buffered in a 2-entry queue.
- Accepts branch/jump redirects that flush all stale fetches.
- Sits between InstructionMemory and decode in the MIPS core.

Parameters:
- DATA_WIDTH, 32, instruction word width; matches InstructionMemory data.
- ADDR_WIDTH, 10, InstructionMemory word-address width.
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  redirect request this cycle.
- redirect_pc  in  32  redirect target, byte address.
- mem_addr  out  ADDR_WIDTH  word address to InstructionMemory addr.
- mem_data  in  DATA_WIDTH  InstructionMemory data; valid one cycle after addr is sampled.
- inst_valid  out  1  head of queue valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  DATA_WIDTH  instruction at head.
- inst_pc  out  32  byte PC of inst_data.

Behaviour:
- Reset (rst low, immediate, asynchronous):
  - pc_q=RESET_PC, state=BOOT, queue count=0, inflight=0.
  - inst_valid=0, inst_data=0, inst_pc=0.
  - mem_addr=RESET_PC[ADDR_WIDTH+1:2].
- mem_addr = pc_q[ADDR_WIDTH+1:2], combinational from the register. The memory wraps modulo 2^ADDR_WIDTH words; pc_q itself keeps counting in 32 bits.
- States:
  - BOOT: one cycle, no issue, then RUN. Lets the memory leave reset.
  - RUN: normal fetch.
  - FLUSH: entered on redirect_valid in RUN. Lasts one cycle, no issue, then RUN.
- pop = inst_valid && inst_ready.
- issue (RUN only) = !redirect_valid && (count + inflight - pop) < 2. This gives sustained one instruction per cycle.
- On issue: inflight<=1, inflight_pc<=pc_q, pc_q<=pc_q+4. Without issue: inflight<=0.
- Response: when inflight==1 and the state is not FLUSH, push {inflight_pc, mem_data} into the queue. Push and pop in the same cycle are legal; count is unchanged.
- Redirect:
  - In the redirect cycle the queue clears and any response arriving that cycle is discarded.
  - pc_q <= {redirect_pc[31:2],2'b00}; low bits are ignored.
  - FLUSH discards the last possible stale response.
  - Timing: redirect in cycle t; target issued in t+2; inst_valid with the target in t+4.
  - A redirect during FLUSH or BOOT is also honoured: it reloads pc_q and restarts FLUSH.
- Handshake: while inst_valid && !inst_ready, inst_data and inst_pc hold stable. A redirect is the only event allowed to drop inst_valid.
- Ordering: no duplicated or skipped PCs except across a redirect.
- inst_valid = (count != 0); outputs show the queue head.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds two outputs:
  - fetch_count[31:0]: increments on every pop.
  - stall_count[31:0]: increments each cycle with inst_valid && !inst_ready.
  - Both are zeroed by rst and wrap at 2^32.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- fetch_pkg:
  - state enum {BOOT, RUN, FLUSH}.
  - FETCH_Q_DEPTH=2.
  - fetch_entry_t struct {pc[31:0], instr[DATA_WIDTH-1:0]}.
- One sub-module, fetch_queue: 2-entry FIFO with push, pop, synchronous flush, count, head outputs and async active-low reset. It is instantiated once.

Test Plan:
- Reset release, RESET_PC=0, inst_ready=1 → inst_valid first high in the 4th cycle after release with inst_pc=0x0 and inst_data=mem[0]. After that one per cycle: 0x4, 0x8, … with matching words.
- inst_ready low for 5 cycles mid-stream at inst_pc=0x10 → inst_pc/inst_data stay 0x10/mem[4] and count never exceeds 2. On release the sequence is 0x10, 0x14, 0x18 with no gaps or duplicates.
- Redirect to 0x40 with the queue full and a fetch in flight → no old-stream PC is accepted after t. inst_pc=0x40 at t+4, then 0x44.
- redirect_pc=0x43 → the first post-redirect inst_pc is 0x40 with data mem[16].
- RESET_PC=0xFFC, ADDR_WIDTH=10 → mem_addr 0x3FF then 0x000. inst_pc reads 0xFFC then 0x1000 with data mem[1023] then mem[0].
- rst driven low mid-stream between clock edges → inst_valid=0 and mem_addr=RESET_PC word immediately. Re-release repeats the first scenario; perf counters (if FETCH_PERF_EN) read 0.
